// File: rtl/product_acc_pkg.sv
// Shared types and constants for the product accumulator slice.
// Build option: define PRODUCT_ACC_SAT_EN for saturating accumulation.
`timescale 1ns/1ps
package product_acc_pkg;

  localparam int PW_DEF    = 16;
  localparam int ACC_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Minimum bit count to represent (value-1); never returns 0.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product input and burst-sum output handshakes of the product accumulator.
`timescale 1ns/1ps
interface product_accumulator_if
  import product_acc_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int ACC_W = ACC_W_DEF
);

  logic             prod_valid;
  logic             prod_ready;
  logic [PW-1:0]    prod_data;
  logic             sum_valid;
  logic             sum_ready;
  logic [ACC_W-1:0] sum_data;
  logic             sum_ovf;

  // master: the producer/consumer side; slave: the accumulator itself.
  modport master (
    output prod_valid, prod_data, sum_ready,
    input  prod_ready, sum_valid, sum_data, sum_ovf
  );

  modport slave (
    input  prod_valid, prod_data, sum_ready,
    output prod_ready, sum_valid, sum_data, sum_ovf
  );

endinterface

// File: rtl/product_acc_add.sv
// Combinational ACC_W-bit accumulate adder with carry-out.
// Build option: PRODUCT_ACC_SAT_EN clamps the sum to all-ones on carry.
`timescale 1ns/1ps
module product_acc_add
  import product_acc_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [PW-1:0]    prod,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, acc} + (ACC_W+1)'(prod);
  assign carry = full[ACC_W];

`ifdef PRODUCT_ACC_SAT_EN
  // Once clamped, all-ones plus any non-zero product carries again, so the
  // value stays pinned for the rest of the burst.
  assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums bursts of LEN unsigned products and presents each total with a sticky
// overflow flag. Build option: PRODUCT_ACC_SAT_EN (saturate instead of wrap).
`timescale 1ns/1ps
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  product_accumulator_if.slave  bus,
  output logic                  busy
);

  localparam int               CNT_W = clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             accept;
  logic             consume;

  assign accept  = bus.prod_valid & bus.prod_ready;
  assign consume = bus.sum_valid & bus.sum_ready;

  product_acc_add #(
    .PW    (PW),
    .ACC_W (ACC_W)
  ) u_add (
    .acc   (acc_q),
    .prod  (bus.prod_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = ACC_W'(bus.prod_data);
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = (LEN == 1) ? DONE : ACC;
          end
        end

        ACC: begin
          if (accept) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_carry;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
              state_d = DONE;
            end
          end
        end

        DONE: begin
          if (consume) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end

        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  // Handshake flags are registered from the next state so they switch in
  // step with the FSM and never decode combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      bus.sum_valid  <= 1'b0;
      bus.prod_ready <= 1'b1;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      bus.sum_valid  <= (state_d == DONE);
      bus.prod_ready <= (state_d != DONE);
      busy           <= (state_d != IDLE);
    end
  end

  // The accumulator register doubles as the result register: it is frozen in
  // DONE until the consumer takes the sum.
  assign bus.sum_data = acc_q;
  assign bus.sum_ovf  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: three accumulator configurations against a burst-sum model.
`timescale 1ns/1ps
module tb_product_accumulator;
  import product_acc_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clr[N];
  logic        pv[N];
  logic [15:0] pd[N];
  logic        sr_d[N];
  logic        sr_r[N];
  logic        sr[N];
  logic        rand_sr;
  logic        pr[N];
  logic        sv[N];
  logic        ov[N];
  logic        bz[N];
  logic [23:0] sd[N];

  int n_checks = 0;
  int n_pass   = 0;

  // Instance configurations: 0 -> ACC_W 24 LEN 4, 1 -> ACC_W 16 LEN 2, 2 -> ACC_W 24 LEN 1
  function automatic int acc_w(input int i);
    return (i == 1) ? 16 : 24;
  endfunction

  function automatic int len(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  product_accumulator_if #(.PW(16), .ACC_W(24)) if0 ();
  product_accumulator_if #(.PW(16), .ACC_W(16)) if1 ();
  product_accumulator_if #(.PW(16), .ACC_W(24)) if2 ();

  for (genvar g = 0; g < N; g++) begin : g_sr
    assign sr[g] = rand_sr ? sr_r[g] : sr_d[g];
  end

  assign if0.prod_valid = pv[0];
  assign if0.prod_data  = pd[0];
  assign if0.sum_ready  = sr[0];
  assign pr[0] = if0.prod_ready;
  assign sv[0] = if0.sum_valid;
  assign sd[0] = if0.sum_data;
  assign ov[0] = if0.sum_ovf;

  assign if1.prod_valid = pv[1];
  assign if1.prod_data  = pd[1];
  assign if1.sum_ready  = sr[1];
  assign pr[1] = if1.prod_ready;
  assign sv[1] = if1.sum_valid;
  assign sd[1] = 24'(if1.sum_data);
  assign ov[1] = if1.sum_ovf;

  assign if2.prod_valid = pv[2];
  assign if2.prod_data  = pd[2];
  assign if2.sum_ready  = sr[2];
  assign pr[2] = if2.prod_ready;
  assign sv[2] = if2.sum_valid;
  assign sd[2] = if2.sum_data;
  assign ov[2] = if2.sum_ovf;

  product_accumulator #(.PW(16), .ACC_W(24), .LEN(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .bus(if0.slave), .busy(bz[0]));
  product_accumulator #(.PW(16), .ACC_W(16), .LEN(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .bus(if1.slave), .busy(bz[1]));
  product_accumulator #(.PW(16), .ACC_W(24), .LEN(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]), .bus(if2.slave), .busy(bz[2]));

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: a burst is LEN products; its true total is compared
  // against the ACC_W range to produce the flag and the presented value.
  longint unsigned tot[N];
  int              cnt_m[N];
  logic [24:0]     exp_q[N][$];

  function automatic void model_clear(input int i);
    tot[i]   = 0;
    cnt_m[i] = 0;
  endfunction

  function automatic void model_accept(input int i, input int d);
    longint unsigned max_v;
    longint unsigned val;
    logic            ovf;
    tot[i]   += longint'(d);
    cnt_m[i] += 1;
    if (cnt_m[i] == len(i)) begin
      max_v = (64'd1 << acc_w(i)) - 1;
      ovf   = (tot[i] > max_v);
`ifdef PRODUCT_ACC_SAT_EN
      val = ovf ? max_v : tot[i];
`else
      val = tot[i] & max_v;
`endif
      exp_q[i].push_back({ovf, 24'(val)});
      model_clear(i);
    end
  endfunction

  // Random consumer back-pressure, used only while rand_sr is set.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) sr_r[i] = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on every sum handshake and checks that a
  // stalled result stays put with product intake closed.
  logic        prev_wait[N];
  logic [24:0] prev_out[N];
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        prev_wait[i] = 1'b0;
      end else begin
        if (prev_wait[i]) begin
          check($sformatf("hold_valid[%0d]", i), sv[i], 1);
          check($sformatf("hold_data[%0d]", i), {ov[i], sd[i]}, prev_out[i]);
        end
        if (sv[i]) check($sformatf("ready_low_in_done[%0d]", i), pr[i], 0);
        if (sv[i] && sr[i]) begin
          check($sformatf("sum_expected[%0d]", i), exp_q[i].size() > 0, 1);
          if (exp_q[i].size() > 0)
            check($sformatf("sum[%0d]", i), {ov[i], sd[i]}, exp_q[i].pop_front());
        end
        prev_wait[i] = sv[i] && !sr[i];
        prev_out[i]  = {ov[i], sd[i]};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one product and wait (bounded) until it is accepted.
  task automatic send(input int i, input int d);
    int n;
    pv[i] = 1'b1;
    pd[i] = 16'(d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pr[i] && n < 200);
    if (!pr[i]) begin
      check($sformatf("accept_timeout[%0d]", i), pr[i], 1);
      pv[i] = 1'b0;
    end else begin
      tick();
      pv[i] = 1'b0;
      model_accept(i, d);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_prod_ready[%0d]", tag, i), pr[i], 1);
      check($sformatf("%s_sum_valid[%0d]", tag, i), sv[i], 0);
      check($sformatf("%s_sum_data[%0d]", tag, i), sd[i], 0);
      check($sformatf("%s_sum_ovf[%0d]", tag, i), ov[i], 0);
      check($sformatf("%s_busy[%0d]", tag, i), bz[i], 0);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 500; n++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
      tick();
    end
    for (int i = 0; i < N; i++) check($sformatf("drain_empty[%0d]", i), exp_q[i].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rand_sr = 1'b0;
    for (int i = 0; i < N; i++) begin
      clr[i] = 1'b0; pv[i] = 1'b0; pd[i] = '0; sr_d[i] = 1'b1;
      model_clear(i);
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Back-to-back burst 6+20+143+1 with consumer ready.
    send(0, 6); send(0, 20); send(0, 143);
    check("no_early_valid", sv[0], 0);
    check("busy_in_acc", bz[0], 1);
    send(0, 1);
    check("latency_valid", sv[0], 1);
    check("latency_data", sd[0], 170);
    tick();
    check("idle_after_hs_valid", sv[0], 0);
    check("idle_after_hs_ready", pr[0], 1);
    check("idle_after_hs_busy", bz[0], 0);

    // Same burst with the consumer stalled for five cycles.
    sr_d[0] = 1'b0;
    send(0, 6); send(0, 20); send(0, 143); send(0, 1);
    repeat (5) begin
      tick();
      check("stall_valid", sv[0], 1);
      check("stall_data", sd[0], 170);
      check("stall_ready", pr[0], 0);
    end
    sr_d[0] = 1'b1;
    tick();
    check("post_stall_valid", sv[0], 0);
    check("post_stall_ready", pr[0], 1);

    // Overflow on the 16-bit instance.
    send(1, 16'hFFFF); send(1, 16'h0002);
`ifdef PRODUCT_ACC_SAT_EN
    check("ovf_data", sd[1], 24'h00FFFF);
`else
    check("ovf_data", sd[1], 24'h000001);
`endif
    check("ovf_flag", ov[1], 1);
    tick();

    // Soft clear mid-burst together with a product that must be dropped.
    send(0, 5); send(0, 7);
    pv[0] = 1'b1; pd[0] = 16'd9; clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0; pv[0] = 1'b0;
    model_clear(0);
    check("clr_busy", bz[0], 0);
    check("clr_ready", pr[0], 1);
    check("clr_valid", sv[0], 0);
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    check("after_clr_data", sd[0], 10);
    tick();

    // Asynchronous reset in the middle of a burst.
    send(0, 3); send(0, 4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    for (int i = 0; i < N; i++) begin
      model_clear(i);
      exp_q[i].delete();
    end
    #3 rst_n = 1'b1;
    tick();
    send(0, 10); send(0, 20); send(0, 30); send(0, 40);
    check("recovery_data", sd[0], 100);
    tick();

    // LEN=1: every product is its own burst, with gaps in prod_valid.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(2, 65025);
      check("len1_valid", sv[2], 1);
    end
    drain();

    // Randomized bursts, random gaps, random consumer back-pressure.
    rand_sr = 1'b1;
    for (int i = 0; i < N; i++) begin
      for (int b = 0; b < 6 * len(3 - 1 - i + 0 == 0 ? 0 : i) / len(i) + 6; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send(i, int'($urandom_range(0, 65535)));
      end
    end
    drain();
    rand_sr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
